// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: interstage pipeline register with a valid/ready handshake.
// SKID=0 gives a single register whose in_ready is combinational from
// out_ready. SKID=1 adds a second (skid) entry so in_ready can be
// registered, cutting the stall path between stages. Stored invalid
// entries are always all-zero, so out_data reads zero on a bubble.
// Includes a synchronous flush and saturating stall/starve counters.
`timescale 1ns/1ps

module pipe_skid_reg #(
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              bubble,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  starve_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_starve_cnt;

  // Saturating increment: hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign bubble     = ~out_valid;
  assign occupancy  = r_state;
  assign stall_cnt  = r_stall_cnt;
  assign starve_cnt = r_starve_cnt;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;
      // Registered ready: refuse new input only while both entries are full.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_in_ready <= 1'b1;
        else        r_in_ready <= (w_state_nxt != ST_TWO);
      end
      assign in_ready = r_in_ready;
    end else begin : g_comb
      // Single register: can take a new op if empty or if the held op leaves now.
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Next-state and payload movement; flush overrides every transfer.
  // With SKID=0 the ONE->TWO path is unreachable because an input transfer
  // while full implies out_ready, so the same table serves both modes.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = in_data;
          end else if (w_in_xfer) begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = in_data;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
          end
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  // State and payload registers; reset drops every held op at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Performance counters: clear wins over a coinciding increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_starve_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt  <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) r_stall_cnt  <= sat_inc(r_stall_cnt);
      if (!out_valid && out_ready) r_starve_cnt <= sat_inc(r_starve_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: one SKID=1 and one SKID=0 instance share the
// same stimulus. A queue per instance holds accepted ops; a monitor process
// compares status every cycle and pops/compares on every output transfer.
`timescale 1ns/1ps

module tb_pipe_skid_reg;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          flush;
  logic          clr_cnt;

  logic          s_in_ready, s_out_valid, s_bubble;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_occ;
  logic [CW-1:0] s_stall, s_starve;
  logic          c_in_ready, c_out_valid, c_bubble;
  logic [DW-1:0] c_out_data;
  logic [1:0]    c_occ;
  logic [CW-1:0] c_stall, c_starve;

  pipe_skid_reg #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .bubble(s_bubble), .flush(flush), .clr_cnt(clr_cnt),
    .occupancy(s_occ), .stall_cnt(s_stall), .starve_cnt(s_starve)
  );

  pipe_skid_reg #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_comb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .bubble(c_bubble), .flush(flush), .clr_cnt(clr_cnt),
    .occupancy(c_occ), .stall_cnt(c_stall), .starve_cnt(c_starve)
  );

  // Reference model state: index 1 = skid instance, index 0 = comb instance.
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_c[$];
  int  exp_stall[2];
  int  exp_starve[2];
  bit  mv[2];
  int  errors;
  int  checks;
  bit  mon_en;
  bit  in_rst;
  logic snap_ir_s, snap_ir_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 1) ? q_s.size() : q_c.size();
  endfunction

  function automatic logic [DW-1:0] qfront(input int i);
    if (i == 1) return (q_s.size() > 0) ? q_s[0] : '0;
    return (q_c.size() > 0) ? q_c[0] : '0;
  endfunction

  task automatic check_dut(input int i, input logic ir, input logic ov, input logic bb,
                           input logic [DW-1:0] od, input logic [1:0] occ,
                           input logic [CW-1:0] st, input logic [CW-1:0] sv);
    int sz;
    string p;
    logic exp_ir;
    sz = qsize(i);
    p = (i == 1) ? "skid" : "comb";
    exp_ir = (i == 1) ? (sz < 2) : ((sz == 0) || out_ready);
    chk({p, ".occupancy"}, 64'(occ), 64'(sz));
    chk({p, ".out_valid"}, 64'(ov), 64'(sz > 0));
    chk({p, ".bubble"}, 64'(bb), 64'(sz == 0));
    chk({p, ".out_data"}, 64'(od), 64'(qfront(i)));
    chk({p, ".in_ready"}, 64'(ir), 64'(exp_ir));
    chk({p, ".stall_cnt"}, 64'(st), 64'(exp_stall[i]));
    chk({p, ".starve_cnt"}, 64'(sv), 64'(exp_starve[i]));
    mv[i] = (sz > 0);
  endtask

  task automatic xfer(input int i, input logic ov, input logic [DW-1:0] od);
    logic [DW-1:0] e;
    string p;
    p = (i == 1) ? "skid" : "comb";
    if (ov && out_ready) begin
      if (qsize(i) == 0) begin
        chk({p, ".spurious_output"}, 64'(ov), 64'(0));
      end else begin
        e = (i == 1) ? q_s.pop_front() : q_c.pop_front();
        chk({p, ".sb_data"}, 64'(od), 64'(e));
      end
    end
  endtask

  // Monitor: status check early in the low phase, output transfer and
  // counter model update just before the rising edge.
  initial begin
    mv[0] = 1'b0;
    mv[1] = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && !in_rst) begin
        check_dut(1, s_in_ready, s_out_valid, s_bubble, s_out_data, s_occ, s_stall, s_starve);
        check_dut(0, c_in_ready, c_out_valid, c_bubble, c_out_data, c_occ, c_stall, c_starve);
      end
      #2;
      if (mon_en && !in_rst) begin
        xfer(1, s_out_valid, s_out_data);
        xfer(0, c_out_valid, c_out_data);
        for (int i = 0; i < 2; i++) begin
          if (clr_cnt) begin
            exp_stall[i]  = 0;
            exp_starve[i] = 0;
          end else begin
            if (mv[i] && !out_ready && exp_stall[i] < CMAX) exp_stall[i]++;
            if (!mv[i] && out_ready && exp_starve[i] < CMAX) exp_starve[i]++;
          end
        end
      end
    end
  end

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic orr,
                       input logic fl, input logic cl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
    clr_cnt   = cl;
  endtask

  // Upstream side: record accepted ops, drop them all on flush; returns
  // just after the rising edge so registered outputs can be inspected.
  task automatic finish_cyc();
    #2;
    snap_ir_s = s_in_ready;
    snap_ir_c = c_in_ready;
    if (in_valid && s_in_ready && !flush) q_s.push_back(in_data);
    if (in_valid && c_in_ready && !flush) q_c.push_back(in_data);
    #2;
    if (flush) begin
      q_s.delete();
      q_c.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic orr,
                     input logic fl, input logic cl);
    drive(iv, d, orr, fl, cl);
    finish_cyc();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mon_en = 1'b0;
    in_rst = 1'b0;
    exp_stall[0] = 0; exp_stall[1] = 0;
    exp_starve[0] = 0; exp_starve[1] = 0;
    reset = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.skid.out_valid", 64'(s_out_valid), 64'(0));
    chk("rst.skid.out_data", 64'(s_out_data), 64'(0));
    chk("rst.skid.occupancy", 64'(s_occ), 64'(0));
    chk("rst.skid.in_ready", 64'(s_in_ready), 64'(1));
    chk("rst.skid.stall", 64'(s_stall), 64'(0));
    chk("rst.comb.in_ready", 64'(c_in_ready), 64'(1));
    chk("rst.comb.out_valid", 64'(c_out_valid), 64'(0));
    #1;
    reset = 1'b1;
    mon_en = 1'b1;

    // Back-pressure fill and drain
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 16'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h22, 1'b0, 1'b0, 1'b0);
    chk("bp.in_ready_after_B", 64'(s_in_ready), 64'(0));
    chk("bp.occupancy", 64'(s_occ), 64'(2));
    repeat (3) cyc(1'b1, 16'h33, 1'b0, 1'b0, 1'b0);
    chk("bp.stall_cnt", 64'(s_stall), 64'(4));
    chk("bp.C_held", 64'(s_in_ready), 64'(0));
    cyc(1'b1, 16'h33, 1'b1, 1'b0, 1'b0);
    chk("bp.drain1", 64'(s_out_data), 64'(16'h22));
    cyc(1'b1, 16'h33, 1'b1, 1'b0, 1'b0);
    chk("bp.drain2", 64'(s_out_data), 64'(16'h33));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("bp.drained", 64'(s_out_valid), 64'(0));
    chk("bp.stall_final", 64'(s_stall), 64'(4));

    // Flush with simultaneous input
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'hA1, 1'b0, 1'b0, 1'b0);
    chk("fl.occ_before", 64'(s_occ), 64'(1));
    cyc(1'b1, 16'hB2, 1'b0, 1'b1, 1'b0);
    chk("fl.out_valid", 64'(s_out_valid), 64'(0));
    chk("fl.out_data", 64'(s_out_data), 64'(0));
    chk("fl.in_ready", 64'(s_in_ready), 64'(1));
    chk("fl.comb.out_valid", 64'(c_out_valid), 64'(0));
    repeat (3) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("fl.B_never_seen", 64'(s_out_valid), 64'(0));

    // Reset mid-stream with two ops held
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h55, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h66, 1'b0, 1'b0, 1'b0);
    chk("mrst.occ_before", 64'(s_occ), 64'(2));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    in_rst = 1'b1;
    reset = 1'b0;
    q_s.delete();
    q_c.delete();
    for (int i = 0; i < 2; i++) begin
      exp_stall[i] = 0;
      exp_starve[i] = 0;
    end
    #1;
    chk("mrst.out_valid", 64'(s_out_valid), 64'(0));
    chk("mrst.out_data", 64'(s_out_data), 64'(0));
    chk("mrst.occupancy", 64'(s_occ), 64'(0));
    chk("mrst.in_ready", 64'(s_in_ready), 64'(1));
    chk("mrst.stall", 64'(s_stall), 64'(0));
    chk("mrst.starve", 64'(s_starve), 64'(0));
    #1;
    reset = 1'b1;
    #2;
    in_rst = 1'b0;

    // Streaming, no back-pressure
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, DW'(16'h100 + i), 1'b1, 1'b0, 1'b0);
      chk("st.in_ready_pre", 64'(snap_ir_s), 64'(1));
      chk("st.latency", 64'(s_out_data), 64'(16'h100 + i));
    end
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("st.stall_cnt", 64'(s_stall), 64'(0));

    // Counter saturation and clear
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    repeat (20) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("cnt.starve_sat", 64'(s_starve), 64'(15));
    chk("cnt.comb_starve_sat", 64'(c_starve), 64'(15));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("cnt.starve_hold", 64'(s_starve), 64'(15));
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("cnt.starve_clr", 64'(s_starve), 64'(0));

    // SKID=0 combinational ready
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h77, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h88, 1'b0, 1'b0, 1'b0);
    chk("c0.in_ready_held", 64'(snap_ir_c), 64'(0));
    chk("c0.holds_A", 64'(c_out_data), 64'(16'h77));
    cyc(1'b1, 16'h88, 1'b1, 1'b0, 1'b0);
    chk("c0.in_ready_comb", 64'(snap_ir_c), 64'(1));
    chk("c0.B_latched", 64'(c_out_data), 64'(16'h88));
    chk("c0.valid", 64'(c_out_valid), 64'(1));

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0,
          ($urandom % 20) == 0, ($urandom % 40) == 0);
    end
    repeat (4) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("end.skid_empty", 64'(s_occ), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
